// File: rtl/fifo_pkg.sv
// Shared FIFO pointer definitions: default depth and Gray/binary conversions
// used by both the write-side and read-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;

  // Conversions work on a wide word; callers cast down to their pointer width.
  localparam int PTR_MAX = 32;

  function automatic logic [PTR_MAX-1:0] bin_to_gray(input logic [PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray_to_bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin[PTR_MAX-1] = gray[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter block, purely combinational.
module gray2bin
  import fifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray_to_bin(PTR_MAX'(gray)));

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded pointer crossing into clk.
module sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  // NOTE: sequential state uses non-blocking assignments so stage1 -> q
  // forms a true two-register chain rather than collapsing into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/almost-full control for an async FIFO: synchronizes
// the read pointer, advances the write pointer and derives the fill status.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rq2;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_match;
  logic             wr_ready;

  sync_2ff #(.WIDTH(PTR_W)) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray_async),
    .q   (rq2)
  );

  gray2bin #(.WIDTH(PTR_W)) u_rptr_bin (
    .gray (rq2),
    .bin  (rbin)
  );

  // Acceptance looks only at the registered full flag; wr_ready keeps the
  // strobe low through the first cycle after reset is released.
  assign wr_en      = winc & ~full & wr_ready & ~rst;
  assign wbin_next  = wbin + PTR_W'(wr_en);
  assign wgray_next = PTR_W'(bin_to_gray(PTR_MAX'(wbin_next)));
  assign level_next = wbin_next - rbin;
  assign waddr      = wbin[ADDR_WIDTH-1:0];

  // Full when the write pointer leads the read pointer by exactly one lap:
  // in Gray code that is the read pointer with its top two bits inverted.
  assign full_match = {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
      wr_ready    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= (wgray_next == full_match);
      almost_full <= (level_next >= AF_LEVEL);
      wlevel      <= level_next;
      overflow    <= overflow | (winc & full);
      wr_ready    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: a count-based model predicts every edge.
module tb_wptr_full_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [4:0] rptr_gray_async;
  logic       wr_en;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wlevel;
  logic       overflow;

  wptr_full_ctrl #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .winc            (winc),
    .rptr_gray_async (rptr_gray_async),
    .wr_en           (wr_en),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .almost_full     (almost_full),
    .wlevel          (wlevel),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] waddr;
    logic [4:0] wgray;
    logic [4:0] wlevel;
    logic       full;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: binary write count, read pointer in the two sync stages.
  logic [4:0] m_w, m_r1, m_r2, m_level;
  logic       m_full, m_af, m_ovf, m_ready;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] rb);
    exp_t e;
    exp_t o;
    logic acc;
    @(negedge clk);
    rst = r;
    winc = w;
    rptr_gray_async = to_gray(rb);
    #1;
    acc = !r && m_ready && w && !m_full;
    check("wr_en", wr_en, acc);
    if (r) begin
      m_w = '0; m_r1 = '0; m_r2 = '0; m_level = '0;
      m_full = 0; m_af = 0; m_ovf = 0; m_ready = 0;
    end else begin
      m_ovf   = m_ovf | (w & m_full);
      m_w     = m_w + 5'(acc);
      m_level = m_w - m_r2;
      m_full  = (m_level == 5'd16);
      m_af    = (m_level >= 5'd12);
      m_r2    = m_r1;
      m_r1    = rb;
      m_ready = 1;
    end
    e.waddr = m_w[3:0];
    e.wgray = to_gray(m_w);
    e.wlevel = m_level;
    e.full = m_full;
    e.af = m_af;
    e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      o = sb.pop_front();
      check("waddr", waddr, o.waddr);
      check("wptr_gray", wptr_gray, o.wgray);
      check("wlevel", wlevel, o.wlevel);
      check("full", full, o.full);
      check("almost_full", almost_full, o.af);
      check("overflow", overflow, o.ovf);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] rin;
    m_w = '0; m_r1 = '0; m_r2 = '0; m_level = '0;
    m_full = 0; m_af = 0; m_ovf = 0; m_ready = 0;
    rst = 1; winc = 0; rptr_gray_async = '0;

    // Reset for two edges, with winc high to show it is ignored.
    step(1, 1, 0);
    step(1, 0, 0);
    check("rst_outputs", {waddr, wptr_gray, full, almost_full, wlevel, overflow}, 0);

    // First post-reset cycle: a write request must not be accepted.
    step(0, 1, 0);
    check("post_rst_no_write", wptr_gray, 5'b00000);

    // Fill with the read pointer parked at zero.
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0);
      check("fill_af", almost_full, (i >= 12));
      check("fill_full", full, (i == 16));
    end
    check("fill_gray", wptr_gray, 5'b11000);
    check("fill_level", wlevel, 5'd16);

    // Write while full: rejected and sticky overflow raised.
    step(0, 1, 0);
    check("ovf_gray", wptr_gray, 5'b11000);
    check("ovf_flag", overflow, 1);

    // Read releases four entries; flags react on the third edge.
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 5'd4);
      check("rel_full", full, (i < 3));
    end
    check("rel_level", wlevel, 5'd12);
    check("rel_af", almost_full, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 5'd10);
    check("rel2_level", wlevel, 5'd6);
    check("rel2_af", almost_full, 0);
    check("ovf_sticky", overflow, 1);

    // One more write to reach level 7, then reset with winc high.
    step(0, 1, 5'd10);
    check("pre_rst_level", wlevel, 5'd7);
    step(1, 1, 5'd0);
    check("mid_rst_outputs", {waddr, wptr_gray, full, almost_full, wlevel, overflow}, 0);

    // Wrap-around: read pointer tracks the exported write pointer.
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      rin = m_w;
      step(0, 1, rin);
      check("wrap_no_full", full, 0);
      check("wrap_level_le3", (wlevel <= 5'd3), 1);
    end
    check("wrap_gray", wptr_gray, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning FIFO depth is 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter AF_THRESH, default 12, meaning the fill level at or above which almost_full asserts.
REQ-003 SHALL have port clk, input, 1, the single write-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port winc, input, 1, write request from the producer.
REQ-006 SHALL have port rptr_gray_async, input, ADDR_WIDTH+1, Gray-coded read pointer from the read domain, not yet synchronized.
REQ-007 SHALL have port wr_en, output, 1, RAM write strobe, combinational winc & ~full.
REQ-008 SHALL have port waddr, output, ADDR_WIDTH, RAM write address: the low bits of the binary write pointer.
REQ-009 SHALL have port wptr_gray, output, ADDR_WIDTH+1, registered Gray write pointer for export to the read domain.
REQ-010 SHALL have port full, output, 1, registered full flag.
REQ-011 SHALL have port almost_full, output, 1, registered flag, asserted when wlevel >= AF_THRESH.
REQ-012 SHALL have port wlevel, output, ADDR_WIDTH+1, registered fill level, range 0..2**ADDR_WIDTH.
REQ-013 SHALL have port overflow, output, 1, sticky error flag: winc was seen while full.

Function
REQ-014 SHALL synchronize rptr_gray_async through two clk flops (rq1, then rq2) before any use.
REQ-015 SHALL convert rq2 to binary rbin combinationally, where each rbin bit is the XOR of that rq2 bit and all higher rq2 bits.
REQ-016 SHALL compute wbin_next = wbin + 1 when wr_en is high, otherwise wbin_next = wbin; the addition is modulo 2**(ADDR_WIDTH+1) and wraps silently.
REQ-017 SHALL register wbin <= wbin_next and wptr_gray <= wbin_next ^ (wbin_next >> 1) on each edge.
REQ-018 SHALL register full <= (gray(wbin_next) == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}).
REQ-019 SHALL register wlevel <= wbin_next - rbin, taken modulo 2**(ADDR_WIDTH+1).
REQ-020 SHALL register almost_full <= (wbin_next - rbin) >= AF_THRESH.
REQ-021 SHALL ignore winc while full: wbin and wptr_gray hold, wr_en stays 0, and overflow is set to 1 on that edge.
REQ-022 SHALL, when winc arrives in the same cycle that a read-pointer update clears full internally, reject that write; acceptance is decided only by the registered full value.
REQ-023 SHALL show a read-pointer change on full, wlevel and almost_full exactly 3 clk edges after it appears on rptr_gray_async (2 synchronizer edges plus 1 flag edge).
REQ-024 SHALL show an accepted write on waddr, wptr_gray, full and wlevel at the next edge (1-cycle latency).
REQ-025 SHALL keep overflow at 1 until rst is applied.

Reset
REQ-026 SHALL, on any edge with rst=1, clear wbin, wptr_gray, rq1, rq2, full, almost_full, wlevel and overflow to 0.
REQ-027 SHALL let a reset applied mid-stream override any winc in the same cycle, so no write is accepted on that edge.
REQ-028 SHALL hold wr_en at 0 while rst=1 and for the whole of the first post-reset cycle.

Structure
REQ-029 SHALL take ADDR_WIDTH and the bin-to-Gray and Gray-to-bin functions from the shared fifo_pkg include, used by both pointer blocks.
REQ-030 SHALL place the two-flop synchronizer in a sub-module sync_2ff, parameterized by width, shared with the read side.
REQ-031 SHALL use the existing Gray-to-binary converter block for the REQ-015 conversion.

Verification (ADDR_WIDTH=4, AF_THRESH=12)
REQ-032 SHALL cover reset: rst=1 for 2 edges -> all outputs 0, waddr=0.
REQ-033 SHALL cover fill: rptr held at 00000, 16 consecutive winc -> almost_full asserts on the 12th accepted edge, full on the 16th, wptr_gray=11000, wlevel=16.
REQ-034 SHALL cover write while full: 1 extra winc -> wr_en=0, wptr_gray stays 11000, overflow=1, and overflow remains 1 afterward.
REQ-035 SHALL cover read release: rptr_gray_async=00110 (binary 4) -> full drops and wlevel=12 exactly 3 edges later, almost_full stays 1; rptr=01111 (binary 10) -> wlevel=6, almost_full=0.
REQ-036 SHALL cover wrap-around: 32 writes with rptr tracking wptr at 2-cycle lag -> wptr_gray returns to 00000, full never asserts, wlevel <= 3.
REQ-037 SHALL cover mid-stream reset: rst asserted with winc=1 while wlevel=7 -> next edge all outputs 0, no write accepted.
